// File: rtl/wshb_arbiter_if.sv
// Wishbone B4 bus bundle shared by the video masters and the SDRAM slave port.
// The master drives the request fields; the slave returns ack/err/rty and read data.
interface wshb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_ms;
    logic [DW-1:0]   dat_sm;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            cyc;
    logic            stb;
    logic            ack;
    logic            err;
    logic            rty;

    modport master (
        output adr, dat_ms, we, sel, cti, bte, cyc, stb,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  adr, dat_ms, we, sel, cti, bte, cyc, stb,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter: writer (M0) and VGA reader (M1) onto one SDRAM port.
// Round-robin with an ack quantum; `define WSHB_ARB_FIXED_PRIO_EN for fixed M1 priority.
module wshb_arbiter #(
    parameter int QUANTUM = 16
) (
    input  logic       clk,
    input  logic       nrst,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [7:0] QMAX = 8'(QUANTUM);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       req0;
    logic       req1;
    logic       hold_cyc;
    logic       oth_req;
    logic       q_hit;
    logic       rel;
`ifndef WSHB_ARB_FIXED_PRIO_EN
    logic       last;
`endif

    assign req0 = wshb_ifs0.cyc & wshb_ifs0.stb;
    assign req1 = wshb_ifs1.cyc & wshb_ifs1.stb;

    always_comb begin
        hold_cyc = 1'b0;
        oth_req  = 1'b0;
        case (state)
            GNT0: begin
                hold_cyc = wshb_ifs0.cyc;
                oth_req  = req1;
            end
            GNT1: begin
                hold_cyc = wshb_ifs1.cyc;
                oth_req  = req0;
            end
            default: ;
        endcase
    end

    assign cnt_inc = (cnt == QMAX) ? cnt : cnt + 8'd1;
    // Quantum only bites on an ack cycle, so a pending transfer is never cut.
    assign q_hit   = wshb_ifm.ack && (cnt_inc == QMAX) && oth_req;

`ifdef WSHB_ARB_FIXED_PRIO_EN
    // M1 holds until it lets go of stb (or cyc); only M0 is bounded by the quantum.
    assign rel = (state == GNT0) ? (!hold_cyc || q_hit) : !req1;
`else
    assign rel = !hold_cyc || q_hit;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            gnt   <= 2'b00;
            cnt   <= '0;
`ifndef WSHB_ARB_FIXED_PRIO_EN
            last  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
`ifdef WSHB_ARB_FIXED_PRIO_EN
                    if (req1) begin
                        state <= GNT1;
                        gnt   <= 2'b10;
                    end else if (req0) begin
                        state <= GNT0;
                        gnt   <= 2'b01;
                    end
`else
                    // On contention the master not served last wins.
                    if (req0 && (!req1 || last)) begin
                        state <= GNT0;
                        gnt   <= 2'b01;
                    end else if (req1) begin
                        state <= GNT1;
                        gnt   <= 2'b10;
                    end
`endif
                end
                GNT0, GNT1: begin
                    if (rel) begin
                        state <= IDLE;
                        gnt   <= 2'b00;
`ifndef WSHB_ARB_FIXED_PRIO_EN
                        last  <= (state == GNT1);
`endif
                    end else if (wshb_ifm.ack) begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    // Bus steering straight from the state register: no extra latency on stb.
    always_comb begin
        wshb_ifm.adr     = '0;
        wshb_ifm.dat_ms  = '0;
        wshb_ifm.we      = 1'b0;
        wshb_ifm.sel     = '0;
        wshb_ifm.cti     = '0;
        wshb_ifm.bte     = '0;
        wshb_ifm.cyc     = 1'b0;
        wshb_ifm.stb     = 1'b0;
        wshb_ifs0.ack    = 1'b0;
        wshb_ifs0.err    = 1'b0;
        wshb_ifs0.rty    = 1'b0;
        wshb_ifs0.dat_sm = '0;
        wshb_ifs1.ack    = 1'b0;
        wshb_ifs1.err    = 1'b0;
        wshb_ifs1.rty    = 1'b0;
        wshb_ifs1.dat_sm = '0;
        case (state)
            GNT0: begin
                wshb_ifm.adr     = wshb_ifs0.adr;
                wshb_ifm.dat_ms  = wshb_ifs0.dat_ms;
                wshb_ifm.we      = wshb_ifs0.we;
                wshb_ifm.sel     = wshb_ifs0.sel;
                wshb_ifm.cti     = wshb_ifs0.cti;
                wshb_ifm.bte     = wshb_ifs0.bte;
                wshb_ifm.cyc     = wshb_ifs0.cyc;
                wshb_ifm.stb     = wshb_ifs0.stb;
                wshb_ifs0.ack    = wshb_ifm.ack;
                wshb_ifs0.err    = wshb_ifm.err;
                wshb_ifs0.rty    = wshb_ifm.rty;
                wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
            end
            GNT1: begin
                wshb_ifm.adr     = wshb_ifs1.adr;
                wshb_ifm.dat_ms  = wshb_ifs1.dat_ms;
                wshb_ifm.we      = wshb_ifs1.we;
                wshb_ifm.sel     = wshb_ifs1.sel;
                wshb_ifm.cti     = wshb_ifs1.cti;
                wshb_ifm.bte     = wshb_ifs1.bte;
                wshb_ifm.cyc     = wshb_ifs1.cyc;
                wshb_ifm.stb     = wshb_ifs1.stb;
                wshb_ifs1.ack    = wshb_ifm.ack;
                wshb_ifs1.err    = wshb_ifm.err;
                wshb_ifs1.rty    = wshb_ifm.rty;
                wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
            end
            default: ;
        endcase
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!nrst)
        !(gnt[0] && gnt[1]));

    a_idle_quiet: assert property (@(posedge clk) disable iff (!nrst)
        (state == IDLE) |-> (!wshb_ifm.cyc && !wshb_ifm.stb));

    // A strobed, unanswered transfer with cyc held must keep its grant.
    a_no_abort: assert property (@(posedge clk) disable iff (!nrst)
        (state != IDLE && hold_cyc && wshb_ifm.stb &&
         !(wshb_ifm.ack || wshb_ifm.err || wshb_ifm.rty)) |=> (state != IDLE));

endmodule
